// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write and M-mode trap-entry sequencer toward the CSR file; response in 4 cycles
// (3 without write, 1 if illegal), TRAP_DONE in 9. Accepts one operation at a time, traps win over requests.
`timescale 1ns/1ps
module csr_access_unit #(
   parameter int XLEN = 64
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic [1:0]      MODE,
   input  logic            REQ_VALID,
   output logic            REQ_READY,
   input  logic [2:0]      REQ_FUNCT3,
   input  logic [11:0]     REQ_CSR,
   input  logic [XLEN-1:0] REQ_SRC,
   input  logic            REQ_SRC_ZERO,
   output logic            RSP_VALID,
   output logic [XLEN-1:0] RSP_DATA,
   output logic            RSP_ILLEGAL,
   input  logic            TRAP_VALID,
   output logic            TRAP_READY,
   input  logic [XLEN-1:0] TRAP_CAUSE,
   input  logic [XLEN-1:0] TRAP_PC,
   input  logic [XLEN-1:0] TRAP_TVAL,
   output logic            TRAP_DONE,
   output logic [XLEN-1:0] TRAP_TVEC,
   output logic [11:0]     CSR_RA,
   input  logic [XLEN-1:0] RCSR,
   output logic [1:0]      CSR_WCMD,
   output logic [11:0]     CSR_WA,
   output logic [XLEN-1:0] CSR_WD
);
   typedef enum logic [3:0] {
      S_IDLE, S_RD, S_WAIT, S_WR, S_RSP,
      S_T_EPC, S_T_CAUSE, S_T_TVAL, S_T_SRD, S_T_SWAIT, S_T_SWR, S_T_VRD, S_T_VWAIT, S_T_DONE
   } state_t;

   state_t          r_state, w_next;
   logic            r_live;
   logic [1:0]      r_op;
   logic [11:0]     r_csr;
   logic [XLEN-1:0] r_src;
   logic            r_wr, r_ill;
   logic [1:0]      r_mode;
   logic [XLEN-1:0] r_cause, r_pc, r_tval, r_old;

   logic            w_req_wr, w_req_ill, w_trap_acc, w_req_acc;
   logic [XLEN-1:0] w_new, w_mstatus;

   // Ready is held low during reset and until the first edge after release.
   assign REQ_READY  = r_live && (r_state == S_IDLE) && !TRAP_VALID;
   assign TRAP_READY = r_live && (r_state == S_IDLE);
   assign w_trap_acc = TRAP_VALID && TRAP_READY;
   assign w_req_acc  = REQ_VALID && REQ_READY;

   // Set/clear forms with a zero operand only read, so they stay legal on read-only CSRs.
   assign w_req_wr  = (REQ_FUNCT3[1:0] == 2'b01) || !REQ_SRC_ZERO;
   assign w_req_ill = (REQ_FUNCT3 == 3'd0) || (REQ_FUNCT3 == 3'd4) ||
                      (REQ_CSR[9:8] > MODE) || ((REQ_CSR[11:10] == 2'b11) && w_req_wr);

   always_comb begin
      w_new = r_src;
      case (r_op)
         2'b10:   w_new = r_old | r_src;
         2'b11:   w_new = r_old & ~r_src;
         default: w_new = r_src;
      endcase
   end

   always_comb begin
      w_mstatus        = r_old;
      w_mstatus[7]     = r_old[3];
      w_mstatus[3]     = 1'b0;
      w_mstatus[12:11] = r_mode;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= S_IDLE;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_live  <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_op      <= '0;
         r_csr     <= '0;
         r_src     <= '0;
         r_wr      <= 1'b0;
         r_ill     <= 1'b0;
         r_mode    <= '0;
         r_cause   <= '0;
         r_pc      <= '0;
         r_tval    <= '0;
         r_old     <= '0;
         TRAP_TVEC <= '0;
      end else begin
         if (w_trap_acc) begin
            r_mode  <= MODE;
            r_cause <= TRAP_CAUSE;
            r_pc    <= TRAP_PC & ~{{(XLEN-1){1'b0}}, 1'b1};
            r_tval  <= TRAP_TVAL;
         end else if (w_req_acc) begin
            r_op   <= REQ_FUNCT3[1:0];
            r_csr  <= REQ_CSR;
            r_src  <= REQ_SRC;
            r_wr   <= w_req_wr;
            r_ill  <= w_req_ill;
            r_mode <= MODE;
            r_old  <= '0;
         end
         if ((r_state == S_WAIT) || (r_state == S_T_SWAIT))
            r_old <= RCSR;
         if (r_state == S_T_VWAIT)
            TRAP_TVEC <= RCSR;
      end
   end

   always_comb begin
      w_next      = r_state;
      RSP_VALID   = 1'b0;
      RSP_DATA    = '0;
      RSP_ILLEGAL = 1'b0;
      TRAP_DONE   = 1'b0;
      CSR_RA      = '0;
      CSR_WCMD    = 2'd0;
      CSR_WA      = '0;
      CSR_WD      = '0;
      case (r_state)
         S_IDLE: begin
            if (w_trap_acc)     w_next = S_T_EPC;
            else if (w_req_acc) w_next = w_req_ill ? S_RSP : S_RD;
         end
         S_RD: begin
            CSR_RA = r_csr;
            w_next = S_WAIT;
         end
         S_WAIT: begin
            CSR_RA = r_csr;
            w_next = r_wr ? S_WR : S_RSP;
         end
         S_WR: begin
            CSR_WCMD = 2'd1;
            CSR_WA   = r_csr;
            CSR_WD   = w_new;
            w_next   = S_RSP;
         end
         S_RSP: begin
            RSP_VALID   = 1'b1;
            RSP_DATA    = r_old;
            RSP_ILLEGAL = r_ill;
            w_next      = S_IDLE;
         end
         S_T_EPC: begin
            CSR_WCMD = 2'd1;
            CSR_WA   = 12'h341;
            CSR_WD   = r_pc;
            w_next   = S_T_CAUSE;
         end
         S_T_CAUSE: begin
            CSR_WCMD = 2'd1;
            CSR_WA   = 12'h342;
            CSR_WD   = r_cause;
            w_next   = S_T_TVAL;
         end
         S_T_TVAL: begin
            CSR_WCMD = 2'd1;
            CSR_WA   = 12'h343;
            CSR_WD   = r_tval;
            w_next   = S_T_SRD;
         end
         S_T_SRD: begin
            CSR_RA = 12'h300;
            w_next = S_T_SWAIT;
         end
         S_T_SWAIT: begin
            CSR_RA = 12'h300;
            w_next = S_T_SWR;
         end
         S_T_SWR: begin
            CSR_WCMD = 2'd1;
            CSR_WA   = 12'h300;
            CSR_WD   = w_mstatus;
            w_next   = S_T_VRD;
         end
         S_T_VRD: begin
            CSR_RA = 12'h305;
            w_next = S_T_VWAIT;
         end
         S_T_VWAIT: begin
            CSR_RA = 12'h305;
            w_next = S_T_DONE;
         end
         S_T_DONE: begin
            TRAP_DONE = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_csr_access_unit.sv
// Randomised bench for csr_access_unit: the bench plays the CSR file and predicts every write,
// response and trap completion from the instruction semantics, checked once per cycle.
`timescale 1ns/1ps
module tb_csr_access_unit;
   localparam int XLEN = 64;

   logic            CLK = 1'b0, RSTn = 1'b0;
   logic [1:0]      MODE = 2'd3;
   logic            REQ_VALID = 1'b0, REQ_SRC_ZERO = 1'b0, TRAP_VALID = 1'b0;
   logic [2:0]      REQ_FUNCT3 = '0;
   logic [11:0]     REQ_CSR = '0;
   logic [XLEN-1:0] REQ_SRC = '0, TRAP_CAUSE = '0, TRAP_PC = '0, TRAP_TVAL = '0, RCSR = '0;
   logic            REQ_READY, RSP_VALID, RSP_ILLEGAL, TRAP_READY, TRAP_DONE;
   logic [XLEN-1:0] RSP_DATA, TRAP_TVEC, CSR_WD;
   logic [11:0]     CSR_RA, CSR_WA;
   logic [1:0]      CSR_WCMD;

   csr_access_unit #(.XLEN(XLEN)) dut (
      .CLK(CLK), .RSTn(RSTn), .MODE(MODE),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_FUNCT3(REQ_FUNCT3), .REQ_CSR(REQ_CSR),
      .REQ_SRC(REQ_SRC), .REQ_SRC_ZERO(REQ_SRC_ZERO),
      .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ILLEGAL(RSP_ILLEGAL),
      .TRAP_VALID(TRAP_VALID), .TRAP_READY(TRAP_READY), .TRAP_CAUSE(TRAP_CAUSE), .TRAP_PC(TRAP_PC),
      .TRAP_TVAL(TRAP_TVAL), .TRAP_DONE(TRAP_DONE), .TRAP_TVEC(TRAP_TVEC),
      .CSR_RA(CSR_RA), .RCSR(RCSR), .CSR_WCMD(CSR_WCMD), .CSR_WA(CSR_WA), .CSR_WD(CSR_WD)
   );

   initial forever #5 CLK = ~CLK;

   typedef struct { int cyc; logic [63:0] data; logic ill; } rsp_t;
   typedef struct { int cyc; logic [11:0] wa; logic [63:0] wd; } wr_t;
   typedef struct { int cyc; logic [63:0] tvec; } done_t;

   rsp_t  rsp_q[$];
   wr_t   wr_q[$];
   done_t done_q[$];

   logic [63:0] dut_mem [4096];
   logic [63:0] ref_mem [4096];
   logic [63:0] rd_pend = '0, exp_tvec = '0, last_rsp_data = '0;
   logic        last_rsp_ill = 1'b0;
   int          cyc = 0, errors = 0, checks = 0, n_writes = 0;
   int          last_rsp_cyc = 0, last_done_cyc = 0;

   localparam int NT = 13;
   logic [11:0] tbl [NT] = '{12'h340, 12'h341, 12'h342, 12'h343, 12'h300, 12'h305, 12'hC00,
                             12'hF11, 12'h100, 12'h140, 12'h000, 12'h7C0, 12'hB00};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // CSR file: registered read (data appears the cycle after the address), write at the edge.
   initial forever begin
      @(negedge CLK);
      rd_pend = dut_mem[CSR_RA];
      if (CSR_WCMD == 2'd1) begin
         dut_mem[CSR_WA] = CSR_WD;
         n_writes++;
      end
      @(posedge CLK);
      #1 RCSR = rd_pend;
   end

   // Per-cycle comparison of all response, write and trap outputs against the predicted queues.
   initial forever begin
      bit exp_v, exp_w, exp_d;
      @(negedge CLK);
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
         chk("rsp_due_cycle", 64'(cyc), 64'(rsp_q[0].cyc));
         void'(rsp_q.pop_front());
      end
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
         chk("write_due_cycle", 64'(cyc), 64'(wr_q[0].cyc));
         void'(wr_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
         chk("done_due_cycle", 64'(cyc), 64'(done_q[0].cyc));
         void'(done_q.pop_front());
      end
      exp_v = rsp_q.size() > 0 && rsp_q[0].cyc == cyc;
      exp_w = wr_q.size() > 0 && wr_q[0].cyc == cyc;
      exp_d = done_q.size() > 0 && done_q[0].cyc == cyc;
      chk("rsp_valid", RSP_VALID, exp_v);
      if (exp_v && RSP_VALID) begin
         chk("rsp_data", RSP_DATA, rsp_q[0].data);
         chk("rsp_illegal", RSP_ILLEGAL, rsp_q[0].ill);
         last_rsp_data = RSP_DATA;
         last_rsp_ill  = RSP_ILLEGAL;
         last_rsp_cyc  = cyc;
         void'(rsp_q.pop_front());
      end
      chk("csr_wcmd", CSR_WCMD, exp_w ? 64'd1 : 64'd0);
      if (exp_w && CSR_WCMD == 2'd1) begin
         chk("csr_wa", CSR_WA, wr_q[0].wa);
         chk("csr_wd", CSR_WD, wr_q[0].wd);
         void'(wr_q.pop_front());
      end
      chk("trap_done", TRAP_DONE, exp_d);
      if (exp_d && TRAP_DONE) begin
         exp_tvec      = done_q[0].tvec;
         last_done_cyc = cyc;
         void'(done_q.pop_front());
      end
      chk("trap_tvec", TRAP_TVEC, exp_tvec);
   end

   // Reference: instruction semantics applied to ref_mem at the cycle of acceptance a.
   function automatic void model_req(input logic [2:0] f3, input logic [11:0] csr, input logic [63:0] src,
                                     input logic sz, input logic [1:0] mode, input int a);
      rsp_t r;
      wr_t  w;
      logic [63:0] old, nv;
      bit is_rw = (f3 == 3'd1) || (f3 == 3'd5);
      bit is_rs = (f3 == 3'd2) || (f3 == 3'd6);
      bit does_wr = is_rw || !sz;
      bit ill = !(is_rw || is_rs || f3 == 3'd3 || f3 == 3'd7) ||
                (int'(csr[9:8]) > int'(mode)) || (csr[11:10] == 2'b11 && does_wr);
      r.ill = ill;
      if (ill) begin
         r.cyc  = a;
         r.data = '0;
      end else begin
         old = ref_mem[csr];
         nv  = is_rw ? src : (is_rs ? (old | src) : (old & ~src));
         r.data = old;
         if (does_wr) begin
            w.cyc = a + 2; w.wa = csr; w.wd = nv;
            wr_q.push_back(w);
            ref_mem[csr] = nv;
            r.cyc = a + 3;
         end else begin
            r.cyc = a + 2;
         end
      end
      rsp_q.push_back(r);
   endfunction

   function automatic void model_trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval,
                                      input logic [1:0] mode, input int a);
      wr_t w;
      done_t d;
      logic [63:0] ms = ref_mem[12'h300];
      logic [63:0] nm = (ms & ~64'h1888) | (64'(ms[3]) << 7) | (64'(mode) << 11);
      w.cyc = a;     w.wa = 12'h341; w.wd = {pc[63:1], 1'b0}; wr_q.push_back(w);
      w.cyc = a + 1; w.wa = 12'h342; w.wd = cause;            wr_q.push_back(w);
      w.cyc = a + 2; w.wa = 12'h343; w.wd = tval;             wr_q.push_back(w);
      w.cyc = a + 5; w.wa = 12'h300; w.wd = nm;               wr_q.push_back(w);
      ref_mem[12'h341] = {pc[63:1], 1'b0};
      ref_mem[12'h342] = cause;
      ref_mem[12'h343] = tval;
      ref_mem[12'h300] = nm;
      d.cyc = a + 8; d.tvec = ref_mem[12'h305];
      done_q.push_back(d);
   endfunction

   task automatic issue_req(input logic [2:0] f3, input logic [11:0] csr, input logic [63:0] src,
                            input logic sz, input logic [1:0] mode, output int a);
      int n = 0;
      @(negedge CLK);
      MODE = mode; REQ_FUNCT3 = f3; REQ_CSR = csr; REQ_SRC = src; REQ_SRC_ZERO = sz; REQ_VALID = 1'b1;
      #1;
      while (!REQ_READY && n < 60) begin
         @(negedge CLK); #1; n++;
      end
      if (!REQ_READY) begin
         chk("req_accept_timeout", REQ_READY, 1'b1);
         REQ_VALID = 1'b0;
         a = -1;
      end else begin
         @(posedge CLK); #1;
         a = cyc;
         REQ_VALID = 1'b0;
         model_req(f3, csr, src, sz, mode, a);
      end
   endtask

   task automatic issue_trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval,
                             input logic [1:0] mode, output int a);
      int n = 0;
      @(negedge CLK);
      MODE = mode; TRAP_CAUSE = cause; TRAP_PC = pc; TRAP_TVAL = tval; TRAP_VALID = 1'b1;
      #1;
      while (!TRAP_READY && n < 60) begin
         @(negedge CLK); #1; n++;
      end
      if (!TRAP_READY) begin
         chk("trap_accept_timeout", TRAP_READY, 1'b1);
         TRAP_VALID = 1'b0;
         a = -1;
      end else begin
         @(posedge CLK); #1;
         a = cyc;
         TRAP_VALID = 1'b0;
         model_trap(cause, pc, tval, mode, a);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((rsp_q.size() + wr_q.size() + done_q.size()) > 0 && n < 40) begin
         @(negedge CLK); n++;
      end
      chk("drain_timeout", 64'(rsp_q.size() + wr_q.size() + done_q.size()), 64'd0);
      @(negedge CLK);
   endtask

   function automatic logic [1:0] rmode();
      int m = $urandom_range(0, 2);
      return (m == 2) ? 2'd3 : 2'(m);
   endfunction

   int a, b, snap;
   logic [63:0] s342, s343, s300, r_src;
   logic r_sz;

   initial begin
      for (int i = 0; i < 4096; i++) begin
         dut_mem[i] = '0;
         ref_mem[i] = '0;
      end
      for (int k = 0; k < NT; k++) begin
         dut_mem[tbl[k]] = {$urandom, $urandom};
         ref_mem[tbl[k]] = dut_mem[tbl[k]];
      end
      dut_mem[12'h340] = 64'h5;          ref_mem[12'h340] = 64'h5;
      dut_mem[12'hC00] = 64'h1234;       ref_mem[12'hC00] = 64'h1234;
      dut_mem[12'h300] = 64'h8;          ref_mem[12'h300] = 64'h8;
      dut_mem[12'h305] = 64'h8000_0000; ref_mem[12'h305] = 64'h8000_0000;

      repeat (3) @(negedge CLK);
      #1;
      chk("rst_req_ready", REQ_READY, 1'b0);
      chk("rst_trap_ready", TRAP_READY, 1'b0);
      chk("rst_rsp_valid", RSP_VALID, 1'b0);
      chk("rst_rsp_data", RSP_DATA, 64'd0);
      chk("rst_csr_ra", CSR_RA, 64'd0);
      chk("rst_csr_wcmd", CSR_WCMD, 64'd0);
      chk("rst_trap_tvec", TRAP_TVEC, 64'd0);
      RSTn = 1'b1;
      @(negedge CLK); #1;
      chk("req_ready_after_reset", REQ_READY, 1'b1);
      chk("trap_ready_after_reset", TRAP_READY, 1'b1);

      // CSRRS mscratch: old 0x5, new 0xF, four-cycle response.
      issue_req(3'd2, 12'h340, 64'hA, 1'b0, 2'd3, a); wait_idle();
      chk("rs_data", last_rsp_data, 64'h5);
      chk("rs_latency", 64'(last_rsp_cyc - a), 64'd3);
      chk("rs_written", dut_mem[12'h340], 64'hF);
      snap = n_writes;
      issue_req(3'd2, 12'h340, 64'h0, 1'b1, 2'd3, a); wait_idle();
      chk("rs0_data", last_rsp_data, 64'hF);
      chk("rs0_latency", 64'(last_rsp_cyc - a), 64'd2);
      chk("rs0_no_write", 64'(n_writes), 64'(snap));
      issue_req(3'd3, 12'h340, 64'h3, 1'b0, 2'd3, a); wait_idle();
      chk("rc_data", last_rsp_data, 64'hF);
      chk("rc_written", dut_mem[12'h340], 64'hC);

      // Read-only counter: write is illegal, pure read is legal.
      snap = n_writes;
      issue_req(3'd1, 12'hC00, 64'h5, 1'b0, 2'd3, a); wait_idle();
      chk("ro_write_illegal", last_rsp_ill, 1'b1);
      chk("ro_write_data", last_rsp_data, 64'd0);
      chk("ro_write_latency", 64'(last_rsp_cyc - a), 64'd0);
      chk("ro_no_write", 64'(n_writes), 64'(snap));
      issue_req(3'd2, 12'hC00, 64'h0, 1'b1, 2'd3, a); wait_idle();
      chk("ro_read_legal", last_rsp_ill, 1'b0);
      chk("ro_read_data", last_rsp_data, 64'h1234);

      // Privilege: mstatus from S is illegal, from M legal.
      issue_req(3'd1, 12'h300, 64'h8, 1'b0, 2'd1, a); wait_idle();
      chk("s_mstatus_illegal", last_rsp_ill, 1'b1);
      issue_req(3'd1, 12'h300, 64'h8, 1'b0, 2'd3, a); wait_idle();
      chk("m_mstatus_legal", last_rsp_ill, 1'b0);
      chk("m_mstatus_old", last_rsp_data, 64'h8);

      // Trap entry from S-mode.
      issue_trap(64'd2, 64'h1001, 64'hDEAD, 2'd1, a); wait_idle();
      chk("trap_latency", 64'(last_done_cyc - a), 64'd8);
      chk("trap_mepc", dut_mem[12'h341], 64'h1000);
      chk("trap_mcause", dut_mem[12'h342], 64'd2);
      chk("trap_mtval", dut_mem[12'h343], 64'hDEAD);
      chk("trap_mstatus", dut_mem[12'h300], 64'h880);
      chk("trap_tvec_lit", TRAP_TVEC, 64'h8000_0000);

      // Trap and request offered together: trap first.
      fork
         issue_trap(64'd11, 64'h3000, 64'h0, 2'd3, a);
         issue_req(3'd2, 12'h340, 64'h0, 1'b1, 2'd3, b);
         begin
            @(negedge CLK); #1;
            chk("req_ready_blocked", REQ_READY, 1'b0);
            chk("trap_ready_both", TRAP_READY, 1'b1);
         end
      join
      wait_idle();
      chk("req_after_trap", 64'(b - a), 64'd10);
      chk("req_after_trap_data", last_rsp_data, 64'hC);

      // Reset pulsed while mcause is being written.
      s342 = ref_mem[12'h342]; s343 = ref_mem[12'h343]; s300 = ref_mem[12'h300];
      issue_trap(64'h7, 64'h2000, 64'h55, 2'd3, a);
      @(posedge CLK); #2;
      RSTn = 1'b0;
      rsp_q.delete(); wr_q.delete(); done_q.delete();
      exp_tvec = '0;
      ref_mem[12'h342] = s342; ref_mem[12'h343] = s343; ref_mem[12'h300] = s300;
      snap = n_writes;
      repeat (3) @(negedge CLK);
      #1;
      chk("midrst_wcmd", CSR_WCMD, 64'd0);
      chk("midrst_trap_ready", TRAP_READY, 1'b0);
      RSTn = 1'b1;
      @(negedge CLK); #1;
      chk("midrst_ready_after", REQ_READY, 1'b1);
      repeat (12) @(negedge CLK);
      chk("midrst_no_writes", 64'(n_writes), 64'(snap));
      chk("midrst_mcause_kept", dut_mem[12'h342], s342);

      // Random mix against the reference model.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 6) == 0) begin
            issue_trap({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, rmode(), a);
         end else begin
            r_sz  = ($urandom_range(0, 3) == 0);
            r_src = r_sz ? 64'd0 : {$urandom, $urandom};
            issue_req(3'($urandom_range(0, 7)), tbl[$urandom_range(0, NT - 1)], r_src, r_sz, rmode(), a);
         end
         MODE = 2'($urandom_range(0, 3));
         wait_idle();
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      for (int k = 0; k < NT; k++)
         chk("final_mem", dut_mem[tbl[k]], ref_mem[tbl[k]]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR file's read/write port.
- Sequences Zicsr instructions (CSRRW/RS/RC and the immediate forms) as read-old-value, compute, write-new-value. Returns the old value to the pipeline for rd.
- Also sequences M-mode trap entry: writes mepc, mcause and mtval, does a read-modify-write of mstatus, then reads mtvec to return the trap target.
- Sits between the execute stage and the CSR file.

Parameters:
XLEN, 64, data width of CSR values and operands.

Ports:
CLK  input  1  clock.
RSTn  input  1  reset, asynchronous, active-low.
MODE  input  2  current privilege (0=U, 1=S, 3=M).
REQ_VALID  input  1  CSR instruction request.
REQ_READY  output  1  high only in IDLE with TRAP_VALID low.
REQ_FUNCT3  input  3  Zicsr funct3 (1=RW, 2=RS, 3=RC, 5=RWI, 6=RSI, 7=RCI).
REQ_CSR  input  12  CSR address.
REQ_SRC  input  XLEN  rs1 value; for the immediate forms, zimm zero-extended.
REQ_SRC_ZERO  input  1  rs1 index / zimm field is zero.
RSP_VALID  output  1  one-cycle pulse, response valid.
RSP_DATA  output  XLEN  old CSR value (0 if illegal).
RSP_ILLEGAL  output  1  qualifies RSP_VALID; illegal-instruction.
TRAP_VALID  input  1  trap-entry request.
TRAP_READY  output  1  high only in IDLE.
TRAP_CAUSE  input  XLEN  mcause value.
TRAP_PC  input  XLEN  faulting PC.
TRAP_TVAL  input  XLEN  mtval value.
TRAP_DONE  output  1  one-cycle pulse, trap entry complete.
TRAP_TVEC  output  XLEN  mtvec value read during trap entry.
CSR_RA  output  12  CSR read address.
RCSR  input  XLEN  CSR read data; registered in the CSR file, valid the cycle after CSR_RA.
CSR_WCMD  output  2  0=CSR_NONE, 1=write full CSR_WD; 2 and 3 are never driven.
CSR_WA  output  12  write address.
CSR_WD  output  XLEN  write data (final value).

Behaviour:
- Reset values: all outputs 0; state IDLE; REQ_READY and TRAP_READY go to 1 on the first cycle after reset release.
- Handshake: a transfer occurs when VALID and READY are both high at a rising edge. Request fields are captured into internal registers at acceptance.
- Priority: if TRAP_VALID and REQ_VALID are both high in IDLE, the trap is accepted and REQ_READY is 0.
- Instruction states:
  - IDLE -> RD: drive CSR_RA = captured CSR.
  - RD -> WAIT: hold CSR_RA.
  - WAIT: RCSR now holds the old value; register it. Go to WR if a write is required, else RSP.
  - WR: CSR_WCMD=1 and CSR_WA=CSR for exactly one cycle.
  - RSP: RSP_VALID=1 for one cycle, then IDLE.
- Latency: acceptance to RSP_VALID is 4 cycles with a write, 3 cycles without.
- New value:
  - RW forms: src.
  - RS forms: old | src.
  - RC forms: old & ~src.
- Write suppression: RS/RC/RSI/RCI with REQ_SRC_ZERO=1 perform no write and are still legal on read-only CSRs. RW/RWI always write.
- Illegal (checked at acceptance; the instruction goes straight to RSP with RSP_ILLEGAL=1, RSP_DATA=0 and no CSR_RA or CSR_WCMD activity):
  - funct3 of 0 or 4;
  - CSR[9:8] > MODE;
  - CSR[11:10]==2'b11 and a write is required.
- Trap states, one cycle each; CSR_WCMD=1 in the listed write states:
  - T_EPC: write 0x341 with {TRAP_PC[XLEN-1:1],0}.
  - T_CAUSE: write 0x342 with TRAP_CAUSE.
  - T_TVAL: write 0x343 with TRAP_TVAL.
  - T_SRD: CSR_RA=0x300.
  - T_SWAIT: register mstatus.
  - T_SWR: write 0x300 with mstatus modified as: bit7 (MPIE) = old bit3, bit3 (MIE) = 0, bits[12:11] (MPP) = captured MODE, all other bits unchanged.
  - T_VRD: CSR_RA=0x305.
  - T_VWAIT: capture RCSR into TRAP_TVEC.
  - T_DONE: TRAP_DONE=1 for one cycle, then IDLE.
- Trap latency: acceptance to TRAP_DONE is 9 cycles.
- TRAP_TVEC holds its value until the next trap.
- CSR_WCMD is 0 in every state not listed above; CSR_WA and CSR_WD are don't-care while CSR_WCMD=0.
- MODE is sampled at acceptance; later changes have no effect on the operation in flight.
- Reset mid-operation: return to IDLE immediately, CSR_WCMD=0, no pending response or TRAP_DONE after reset release.

Test Plan:
- mscratch 0x340 holds 0x5; CSRRS 0x340 with src=0xA, REQ_SRC_ZERO=0 -> RSP_DATA=0x5 at cycle 4; one write of 0xF to 0x340; a later read returns 0xF.
- CSRRC 0x340 with src=0x3 on value 0xF -> RSP_DATA=0xF, writes 0xC. CSRRS with REQ_SRC_ZERO=1 -> RSP at cycle 3, CSR_WCMD never nonzero.
- CSRRW to 0xC00 (cycle) -> RSP_ILLEGAL=1, RSP_DATA=0, no CSR port activity. CSRRS 0xC00 with REQ_SRC_ZERO=1 -> legal, returns the counter value.
- MODE=S, CSRRW to 0x300 -> illegal. MODE=M -> legal.
- mstatus=0x8, mtvec=0x8000_0000, MODE=S; trap with cause=2, PC=0x1001, tval=0xDEAD -> mepc=0x1000, mcause=2, mtval=0xDEAD, mstatus=0x880, TRAP_TVEC=0x8000_0000, TRAP_DONE at cycle 9.
- TRAP_VALID and REQ_VALID asserted together -> trap completes first, then the request is accepted. RSTn pulsed during T_CAUSE -> no further writes, IDLE after release.
